// File: rtl/mac_lane_array.sv
// mac_lane_array: LANES signed multiplies, registered adder tree, saturating packet accumulator
module mac_lane_array #(
  parameter int W_WIDTH   = 8,
  parameter int X_WIDTH   = 8,
  parameter int LANES     = 4,
  parameter int ACC_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  input  logic                         in_first,
  input  logic                         in_last,
  input  logic                         x_unsigned,
  input  logic [LANES*W_WIDTH-1:0]     w,
  input  logic [LANES*X_WIDTH-1:0]     x,
  output logic                         out_valid,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         out_ovf
);
  localparam int PW = W_WIDTH + X_WIDTH + 1;
  localparam int SW = PW + $clog2(LANES);
  logic signed [PW-1:0]        prod_d [LANES];
  logic signed [PW-1:0]        prod_q [LANES];
  logic signed [SW-1:0]        sum_d, sum_q;
  logic signed [ACC_WIDTH:0]   add_d;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                        sat_d, ovf_d, ovf_q;
  logic                        started_q;
  logic                        v1_q, f1_q, l1_q, v2_q, f2_q, l2_q, v3_q, l3_q;
  // per-lane products at full width; x msb only extends when the beat is signed
  always_comb begin
    for (int i = 0; i < LANES; i++)
      prod_d[i] = $signed({{(PW-W_WIDTH){w[i*W_WIDTH+W_WIDTH-1]}}, w[i*W_WIDTH +: W_WIDTH]})
                * $signed({{(PW-X_WIDTH){x[i*X_WIDTH+X_WIDTH-1] & ~x_unsigned}}, x[i*X_WIDTH +: X_WIDTH]});
  end
  // lane sum grown by clog2(LANES) bits so it can never wrap
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++)
      sum_d = sum_d + SW'(prod_q[i]);
  end
  // one extra bit on the add exposes overflow; clamp toward the sign of the true result
  always_comb begin
    add_d = (ACC_WIDTH+1)'(acc_q) + (ACC_WIDTH+1)'(sum_q);
    sat_d = add_d[ACC_WIDTH] != add_d[ACC_WIDTH-1];
    acc_d = f2_q ? ACC_WIDTH'(sum_q)
          : sat_d ? {add_d[ACC_WIDTH], {(ACC_WIDTH-1){~add_d[ACC_WIDTH]}}}
          : add_d[ACC_WIDTH-1:0];
    ovf_d = f2_q ? 1'b0 : ovf_q | sat_d;
  end
  // S1: register products and flags; the first beat after reset always starts a packet
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < LANES; i++) prod_q[i] <= '0;
      v1_q      <= 1'b0;
      f1_q      <= 1'b0;
      l1_q      <= 1'b0;
      started_q <= 1'b0;
    end else begin
      if (in_valid) begin
        for (int i = 0; i < LANES; i++) prod_q[i] <= prod_d[i];
        f1_q      <= in_first | ~started_q;
        l1_q      <= in_last;
        started_q <= 1'b1;
      end
      v1_q <= in_valid;
    end
  end
  // S2: register the lane sum and forward flags
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sum_q <= '0;
      v2_q  <= 1'b0;
      f2_q  <= 1'b0;
      l2_q  <= 1'b0;
    end else begin
      if (v1_q) begin
        sum_q <= sum_d;
        f2_q  <= f1_q;
        l2_q  <= l1_q;
      end
      v2_q <= v1_q;
    end
  end
  // S3: accumulate valid beats only, so bubbles leave the running sum untouched
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc_q <= '0;
      ovf_q <= 1'b0;
      v3_q  <= 1'b0;
      l3_q  <= 1'b0;
    end else begin
      if (v2_q) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        l3_q  <= l2_q;
      end
      v3_q <= v2_q;
    end
  end
  // output: pulse on the last beat of a packet, data and ovf held between results
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= v3_q & l3_q;
      if (v3_q & l3_q) begin
        out_data <= acc_q;
        out_ovf  <= ovf_q;
      end
    end
  end
endmodule

// File: tb/tb_mac_lane_array.sv
// tb_mac_lane_array: scoreboard bench for the lane MAC with a behavioural accumulator model
module tb_mac_lane_array;
  localparam int L = 4;
  localparam int AW = 20;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));
  typedef struct { longint d; bit o; longint c; } exp_t;
  logic clk = 0, rstn = 0;
  logic in_valid = 0, in_first = 0, in_last = 0, x_unsigned = 0;
  logic [L*8-1:0] w = '0, x = '0;
  logic out_valid, out_ovf;
  logic signed [AW-1:0] out_data;
  exp_t sb [$];
  longint cyc = 0, m_acc = 0;
  bit m_ovf = 0, m_started = 0;
  int n_chk = 0, n_fail = 0;
  mac_lane_array #(.W_WIDTH(8), .X_WIDTH(8), .LANES(L), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_first(in_first), .in_last(in_last),
    .x_unsigned(x_unsigned), .w(w), .x(x), .out_valid(out_valid), .out_data(out_data), .out_ovf(out_ovf)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic beat(input logic [31:0] wp, input logic [31:0] xp, input bit f, input bit l, input bit xu);
    longint s = 0, t;
    @(posedge clk); #1;
    in_valid = 1; in_first = f; in_last = l; x_unsigned = xu; w = wp; x = xp;
    for (int i = 0; i < L; i++) begin
      int wi, xi;
      wi = $signed(wp[i*8 +: 8]);
      xi = xu ? int'({24'd0, xp[i*8 +: 8]}) : int'($signed(xp[i*8 +: 8]));
      s += longint'(wi * xi);
    end
    if (f || !m_started) begin
      m_acc = s; m_ovf = 0;
    end else begin
      t = m_acc + s;
      if (t > MAXV) begin t = MAXV; m_ovf = 1; end
      if (t < MINV) begin t = MINV; m_ovf = 1; end
      m_acc = t;
    end
    m_started = 1;
    if (l) sb.push_back('{m_acc, m_ovf, cyc + 4});
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 0;
    end
  endtask
  // compare every emitted result against the oldest scoreboard entry, including its arrival cycle
  always @(negedge clk) begin
    if (rstn && out_valid) begin
      if (sb.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", longint'(out_data), e.d);
        chk("out_ovf", longint'(out_ovf), longint'(e.o));
        chk("latency_cycle", cyc, e.c);
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int wait_n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_data", longint'(out_data), 0);
    chk("rst_ovf", longint'(out_ovf), 0);
    @(posedge clk); #1 rstn = 1;
    beat(32'h04030201, 32'h08070605, 1, 1, 0);
    beat(32'h80808080, 32'h80808080, 1, 1, 0);
    beat(32'h80808080, 32'h7f7f7f7f, 1, 1, 0);
    beat(32'h01010101, 32'hffffffff, 1, 1, 1);
    beat(32'h01010101, 32'hffffffff, 1, 1, 0);
    idle(3);
    beat(32'h04030201, 32'h08070605, 1, 0, 0); idle(2);
    beat(32'h04030201, 32'h08070605, 0, 0, 0); idle(2);
    beat(32'h04030201, 32'h08070605, 0, 1, 0);
    idle(4);
    for (int i = 0; i < 9; i++) beat(32'h80808080, 32'h80808080, i == 0, i == 8, 0);
    beat(32'h04030201, 32'h08070605, 1, 1, 0);
    for (int i = 0; i < 9; i++) beat(32'h80808080, 32'h7f7f7f7f, i == 0, i == 8, 0);
    beat(32'h04030201, 32'h08070605, 1, 0, 0);
    beat(32'h01010101, 32'h02020202, 0, 1, 0);
    for (int p = 0; p < 15; p++) begin
      int nb;
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        beat($urandom, $urandom, b == 0, b == nb - 1, 1'($urandom_range(0, 1)));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
    end
    idle(6);
    chk("drain_before_reset", longint'(sb.size()), 0);
    beat(32'h04030201, 32'h08070605, 1, 0, 0);
    beat(32'h04030201, 32'h08070605, 0, 0, 0);
    @(posedge clk); #1;
    in_valid = 0; rstn = 0; m_started = 0;
    @(negedge clk);
    chk("midrst_valid", longint'(out_valid), 0);
    chk("midrst_data", longint'(out_data), 0);
    chk("midrst_ovf", longint'(out_ovf), 0);
    @(posedge clk); #1 rstn = 1;
    idle(4);
    beat(32'h04030201, 32'h08070605, 0, 1, 0);
    idle(1);
    wait_n = 0;
    while (sb.size() != 0 && wait_n < 20) begin
      @(posedge clk);
      wait_n++;
    end
    chk("scoreboard_empty", longint'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
